s84_result_checker: RTL and testbench



---
 rtl/s84_chk_pkg.sv | 26 ++
 rtl/s84_exp_fifo.sv | 67 ++++++
 rtl/s84_result_checker.sv | 190 +++++++++++++++++++
 tb/tb_s84_result_checker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s84_chk_pkg.sv
// Shared types for the s84 result checker: the ALU result triple and checker FSM states.
package s84_chk_pkg;

    localparam int C_W   = 8;
    localparam int Y_W   = 8;
    localparam int Z_W   = 4;
    localparam int RES_W = C_W + Y_W + Z_W;

    typedef struct packed {
        logic [C_W-1:0] c;
        logic [Y_W-1:0] y;
        logic [Z_W-1:0] z;
    } s84_res_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } chk_state_t;

    // Per-field difference flags ordered {c, y, z}.
    function automatic logic [2:0] field_diff(input s84_res_t a, input s84_res_t b);
        return {(a.c != b.c), (a.y != b.y), (a.z != b.z)};
    endfunction

endpackage

// File: rtl/s84_exp_fifo.sv
// Synchronous FIFO of expected result triples; read data is the registered head, so a
// same-cycle push is never visible to the consumer.
module s84_exp_fifo
    import s84_chk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  s84_res_t                 din,
    output s84_res_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

    s84_res_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_s, pop_s;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == {(PTR_W + 1){1'b0}});
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next pointer/occupancy; full and empty come from the registered count only.
    always_comb begin
        push_s   = push && !full;
        pop_s    = pop && !empty;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/s84_result_checker.sv
// Checks s84 ALU results against a FIFO of expected triples and keeps pass/fail statistics.
// Build option S84_CHK_LOG_EN adds capture of the last mismatching result on last_bad.
module s84_result_checker
    import s84_chk_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NUM_VECTORS = 30,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [7:0]       c_exp,
    input  logic [7:0]       y_exp,
    input  logic [3:0]       z_exp,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [7:0]       c_res,
    input  logic [7:0]       y_res,
    input  logic [3:0]       z_res,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_c,
    output logic             err_y,
    output logic             err_z,
    output logic             underflow,
    output logic             mismatch,
    output logic             done,
    output logic             pass,
    output logic [19:0]      last_bad
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VECTORS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    chk_state_t                state_q, state_d;
    logic [CNT_W-1:0]          vec_count_q, vec_count_d, err_count_q, err_count_d;
    logic [2:0]                err_flags_q, err_flags_d;
    logic                      underflow_q, underflow_d, mismatch_q, mismatch_d;
    logic                      done_q, done_d, pass_q, pass_d;
    s84_res_t                  head_s, res_s, exp_s;
    logic                      fifo_full_s, fifo_empty_s, head_valid_s;
    logic [$clog2(DEPTH):0]    fifo_count_s;
    logic                      accept_s, pop_s, push_s, bad_s, cmp_bad_s;
    logic [2:0]                diff_s;

    assign exp_s     = s84_res_t'({c_exp, y_exp, z_exp});
    assign res_s     = s84_res_t'({c_res, y_res, z_res});
    assign exp_ready = !fifo_full_s;
    assign res_ready = (state_q == RUN);

    s84_exp_fifo #(.DEPTH(DEPTH)) u_exp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (exp_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Handshake and compare decode; the head is trusted only when flag and count agree.
    always_comb begin
        accept_s     = res_valid && res_ready;
        push_s       = exp_valid && !fifo_full_s;
        head_valid_s = !fifo_empty_s && (fifo_count_s != {($clog2(DEPTH) + 1){1'b0}});
        pop_s        = accept_s && head_valid_s;
        diff_s       = field_diff(res_s, head_s);
        cmp_bad_s    = accept_s && head_valid_s && (|diff_s);
        bad_s        = accept_s && (!head_valid_s || (|diff_s));
    end

    // Checker FSM and statistics next-state.
    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        err_flags_d = err_flags_q;
        underflow_d = underflow_q;
        mismatch_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    vec_count_d = CNT_ZERO;
                    err_count_d = CNT_ZERO;
                    err_flags_d = 3'b000;
                    underflow_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (accept_s) begin
                    vec_count_d = sat_inc(vec_count_q);
                    if (head_valid_s) begin
                        err_flags_d = err_flags_q | diff_s;
                    end else begin
                        underflow_d = 1'b1;
                    end
                    if (bad_s) begin
                        err_count_d = sat_inc(err_count_q);
                        mismatch_d  = 1'b1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                    state_d = (vec_count_d == NUM_VEC_C) ? DONE : RUN;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        pass_d = done_d && (err_count_d == CNT_ZERO) && !underflow_d;
    end

    // Checker state and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_count_q <= CNT_ZERO;
            err_count_q <= CNT_ZERO;
            err_flags_q <= 3'b000;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            err_flags_q <= err_flags_d;
            underflow_q <= underflow_d;
            mismatch_q  <= mismatch_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign vec_count = vec_count_q;
    assign err_count = err_count_q;
    assign err_c     = err_flags_q[2];
    assign err_y     = err_flags_q[1];
    assign err_z     = err_flags_q[0];
    assign underflow = underflow_q;
    assign mismatch  = mismatch_q;
    assign done      = done_q;
    assign pass      = pass_q;

`ifdef S84_CHK_LOG_EN
    s84_res_t last_bad_q, last_bad_d;

    // Capture of the last result whose fields disagreed with the expected head.
    always_comb begin
        last_bad_d = last_bad_q;
        if (start && (state_q != RUN)) begin
            last_bad_d = s84_res_t'({RES_W{1'b0}});
        end else if (cmp_bad_s) begin
            last_bad_d = res_s;
        end else begin
            last_bad_d = last_bad_q;
        end
    end

    // Capture register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_bad_q <= s84_res_t'({RES_W{1'b0}});
        end else begin
            last_bad_q <= last_bad_d;
        end
    end

    assign last_bad = last_bad_q;
`else
    assign last_bad = {RES_W{1'b0}};
`endif

endmodule

// File: tb/tb_s84_result_checker.sv
// Scoreboard bench for s84_result_checker: directed vectors, decoupled result monitor.
module tb_s84_result_checker;

    localparam int DEPTH = 8;
    localparam int NUMV  = 30;
    localparam int CNT_W = 16;
`ifdef S84_CHK_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, exp_valid, exp_ready, res_valid, res_ready;
    logic [7:0] c_exp, y_exp, c_res, y_res;
    logic [3:0] z_exp, z_res;
    logic [CNT_W-1:0] vec_count, err_count;
    logic err_c, err_y, err_z, underflow, mismatch, done, pass;
    logic [19:0] last_bad;

    always #5 clk = ~clk;

    s84_result_checker #(.DEPTH(DEPTH), .NUM_VECTORS(NUMV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .c_exp(c_exp), .y_exp(y_exp), .z_exp(z_exp),
        .res_valid(res_valid), .res_ready(res_ready),
        .c_res(c_res), .y_res(y_res), .z_res(z_res),
        .vec_count(vec_count), .err_count(err_count),
        .err_c(err_c), .err_y(err_y), .err_z(err_z),
        .underflow(underflow), .mismatch(mismatch),
        .done(done), .pass(pass), .last_bad(last_bad)
    );

    int checks = 0;
    int errors = 0;

    logic [19:0] mdl_q[$];
    logic [63:0] sb_q[$];
    int          m_vec, m_err;
    logic        m_ec, m_ey, m_ez, m_uf;
    logic [19:0] m_lb;
    logic        acc_pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] vec_of(input int i);
        logic [7:0] a, b;
        logic [3:0] z;
        a = 8'(i * 7 + 1);
        b = 8'(i * 13 + 2);
        z = 4'(i);
        return {a, b, z};
    endfunction

    function automatic logic [63:0] dut_snap();
        return {7'd0, mismatch, err_c, err_y, err_z, underflow, last_bad, vec_count, err_count};
    endfunction

    function automatic logic [63:0] mdl_snap(input logic mis);
        return {7'd0, mis, m_ec, m_ey, m_ez, m_uf, m_lb, m_vec[15:0], m_err[15:0]};
    endfunction

    task automatic mdl_clear();
        m_vec = 0; m_err = 0;
        m_ec = 1'b0; m_ey = 1'b0; m_ez = 1'b0; m_uf = 1'b0;
        m_lb = 20'h00000;
    endtask

    // Monitor: one cycle after every accept, compare the registered outcome with the scoreboard.
    always @(negedge clk) begin
        if (acc_pend) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underrun: result seen with no expected record");
            end else begin
                chk("result", dut_snap(), sb_q.pop_front());
            end
        end else if (!reset) begin
            chk("mismatch_idle", {63'd0, mismatch}, 64'd0);
        end
        acc_pend = res_valid && res_ready && !reset;
    end

    task automatic push(input logic [19:0] e);
        exp_valid = 1'b1;
        {c_exp, y_exp, z_exp} = e;
        @(negedge clk);
        if (exp_ready) mdl_q.push_back(e);
        @(posedge clk); #1;
        exp_valid = 1'b0;
    endtask

    task automatic send(input logic [19:0] r);
        logic [19:0] h;
        logic mis;
        int n;
        res_valid = 1'b1;
        {c_res, y_res, z_res} = r;
        n = 0;
        @(negedge clk);
        while (!res_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!res_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: res_ready=0, required 1");
        end else begin
            mis = 1'b0;
            if (m_vec < 65535) m_vec++;
            if (mdl_q.size() == 0) begin
                m_uf = 1'b1;
                mis  = 1'b1;
            end else begin
                h = mdl_q.pop_front();
                if (h[19:12] != r[19:12]) begin m_ec = 1'b1; mis = 1'b1; end
                if (h[11:4]  != r[11:4])  begin m_ey = 1'b1; mis = 1'b1; end
                if (h[3:0]   != r[3:0])   begin m_ez = 1'b1; mis = 1'b1; end
                if (mis && LOG) m_lb = r;
            end
            if (mis && m_err < 65535) m_err++;
            sb_q.push_back(mdl_snap(mis));
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mdl_clear();
    endtask

    task automatic run_match(input int n, input int base);
        int i;
        i = 0;
        while (i < n) begin
            int k;
            k = (n - i > DEPTH) ? DEPTH : (n - i);
            res_valid = 1'b0;
            for (int j = 0; j < k; j++) push(vec_of(base + i + j));
            for (int j = 0; j < k; j++) send(vec_of(base + i + j));
            i += k;
        end
        res_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; exp_valid = 1'b0; res_valid = 1'b0;
        c_exp = 8'h00; y_exp = 8'h00; z_exp = 4'h0;
        c_res = 8'h00; y_res = 8'h00; z_res = 4'h0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_exp_ready", {63'd0, exp_ready}, 64'd1);
        chk("rst_res_ready", {63'd0, res_ready}, 64'd0);
        chk("rst_done_pass", {62'd0, done, pass}, 64'd0);
        chk("rst_snapshot", dut_snap(), 64'd0);
        @(posedge clk); #1;

        // Three matching results with res_valid held high
        for (int i = 0; i < 3; i++) push(vec_of(i));
        pulse_start();
        for (int i = 0; i < 3; i++) send(vec_of(i));
        res_valid = 1'b0;
        @(negedge clk);
        chk("b_vec3", {48'd0, vec_count}, 64'd3);
        chk("b_err0", {48'd0, err_count}, 64'd0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b_start_in_run", {47'd0, res_ready, vec_count}, {47'd0, 1'b1, 16'd3});
        @(posedge clk); #1;

        // Y-field mismatch
        push(20'hA50F3);
        send(20'hA50E3);
        res_valid = 1'b0;
        @(negedge clk);
        chk("c_flags", {61'd0, err_c, err_y, err_z}, 64'd2);
        chk("c_err1", {48'd0, err_count}, 64'd1);
        chk("c_last_bad", {44'd0, last_bad}, LOG ? 64'hA50E3 : 64'h0);
        @(posedge clk); #1;

        // Full FIFO, push refused during a same-cycle pop
        for (int i = 0; i < DEPTH; i++) push(vec_of(10 + i));
        @(negedge clk);
        chk("d_full", {63'd0, exp_ready}, 64'd0);
        @(posedge clk); #1;
        exp_valid = 1'b1;
        {c_exp, y_exp, z_exp} = 20'hEEEEE;
        send(vec_of(10));
        exp_valid = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        chk("d_count7", {63'd0, exp_ready}, 64'd1);
        @(posedge clk); #1;
        push(vec_of(18));
        @(negedge clk);
        chk("d_full_again", {63'd0, exp_ready}, 64'd0);
        @(posedge clk); #1;
        for (int i = 11; i <= 18; i++) send(vec_of(i));
        res_valid = 1'b0;

        // Finish the run with an error recorded
        run_match(NUMV - 13, 20);
        @(negedge clk);
        chk("e_done_fail", {61'd0, done, pass, res_ready}, 64'b100);
        @(posedge clk); #1;
        res_valid = 1'b1;
        {c_res, y_res, z_res} = 20'h55555;
        repeat (3) @(posedge clk);
        #1 res_valid = 1'b0;
        @(negedge clk);
        chk("e_no_accept", {48'd0, vec_count}, 64'd30);
        @(posedge clk); #1;

        // Restart, then underflow on an empty FIFO
        pulse_start();
        @(negedge clk);
        chk("f_cleared", dut_snap(), 64'd0);
        chk("f_run", {62'd0, res_ready, done}, 64'b10);
        @(posedge clk); #1;
        send(20'h12345);
        res_valid = 1'b0;
        @(negedge clk);
        chk("f_underflow", {30'd0, underflow, vec_count, err_count}, {30'd0, 1'b1, 16'd1, 16'd1});
        @(posedge clk); #1;
        push(vec_of(40));
        send(vec_of(40));
        res_valid = 1'b0;
        run_match(NUMV - 2, 41);
        @(negedge clk);
        chk("g_done_fail", {62'd0, done, pass}, 64'b10);
        @(posedge clk); #1;

        // Clean run of 30 vectors
        pulse_start();
        run_match(NUMV, 70);
        @(negedge clk);
        chk("h_pass", {61'd0, done, pass, res_ready}, 64'b110);
        chk("h_counts", {32'd0, vec_count, err_count}, {32'd0, 16'd30, 16'd0});
        @(posedge clk); #1;

        // Reset part-way through a run
        pulse_start();
        run_match(12, 100);
        push(vec_of(200));
        push(vec_of(201));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_clear();
        mdl_q.delete();
        @(negedge clk);
        chk("i_idle", {60'd0, res_ready, done, pass, exp_ready}, 64'b0001);
        chk("i_vec0", {48'd0, vec_count}, 64'd0);
        @(posedge clk); #1;
        pulse_start();
        send(vec_of(200));
        res_valid = 1'b0;
        @(negedge clk);
        chk("i_fifo_empty", {63'd0, underflow}, 64'd1);
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
